// File: rtl/pipe_pkg.sv
// Shared constants for the processor inter-stage registers: control-bit layout,
// per-stage widths and the skid-buffer occupancy encoding.
package pipe_pkg;

  localparam int CTRL_MEMWR        = 0;
  localparam int CTRL_MEMRD        = 1;
  localparam int CTRL_REGWR        = 2;
  localparam int CTRL_MEMTOREG_LSB = 3;
  localparam int CTRL_MEMTOREG_W   = 2;
  localparam int CTRL_BRANCH       = 5;

  localparam int ID_EX_DATA_W  = 96;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int EX_MEM_DATA_W = 72;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int MEM_WB_DATA_W = 40;
  localparam int MEM_WB_CTRL_W = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_entry.sv
// One held instruction: control + payload with a load enable and a valid bit.
// Control is masked on load so an entry loaded as a bubble can never carry side effects.
module pipe_entry #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_valid_nxt,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid_nxt;
      if (i_load) begin
        r_ctrl <= i_ctrl & {CTRL_W{i_valid_nxt}};
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional
// two-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_v;
  logic              w_main_load;
  logic              w_main_vnxt;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [CTRL_W-1:0] w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data_in;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_main_v & out_ready;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_main_load),
    .i_valid_nxt (w_main_vnxt),
    .i_ctrl      (w_main_ctrl_in),
    .i_data      (w_main_data_in),
    .o_valid     (w_main_v),
    .o_ctrl      (w_main_ctrl),
    .o_data      (out_data)
  );

  if (SKID != 0) begin : g_skid
    logic              r_in_ready;
    logic              w_skid_v;
    logic              w_skid_load;
    logic              w_main_from_skid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    skid_state_e       w_state;
    skid_state_e       w_state_nxt;

    // The entry valid bits are the state register; this just names the occupancy.
    assign w_state = w_skid_v ? ST_TWO : (w_main_v ? ST_ONE : ST_EMPTY);

    always_comb begin
      w_state_nxt      = w_state;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      if (flush) begin
        w_state_nxt = ST_EMPTY;
      end else begin
        case (w_state)
          ST_EMPTY: begin
            if (w_in_xfer) begin
              w_main_load = 1'b1;
              w_state_nxt = ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
              w_main_load = 1'b1;
            end else if (w_in_xfer) begin
              w_skid_load = 1'b1;
              w_state_nxt = ST_TWO;
            end else if (w_out_xfer) begin
              w_state_nxt = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (w_out_xfer) begin
              w_main_load      = 1'b1;
              w_main_from_skid = 1'b1;
              w_state_nxt      = ST_ONE;
            end
          end
          default: w_state_nxt = ST_EMPTY;
        endcase
      end
    end

    // in_ready is a pure flop so out_ready never reaches the upstream stage combinationally.
    always_ff @(posedge clk) begin
      if (reset) r_in_ready <= 1'b1;
      else       r_in_ready <= (w_state_nxt != ST_TWO);
    end

    assign in_ready       = r_in_ready;
    assign w_main_vnxt    = (w_state_nxt != ST_EMPTY);
    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_skid_load),
      .i_valid_nxt (w_state_nxt == ST_TWO),
      .i_ctrl      (in_ctrl),
      .i_data      (in_data),
      .o_valid     (w_skid_v),
      .o_ctrl      (w_skid_ctrl),
      .o_data      (w_skid_data)
    );
  end else begin : g_single
    assign in_ready       = out_ready | ~w_main_v;
    assign w_main_load    = w_in_xfer & ~flush;
    assign w_main_vnxt    = ~flush & (w_in_xfer | (w_main_v & ~w_out_xfer));
    assign w_main_ctrl_in = in_ctrl;
    assign w_main_data_in = in_data;
  end

  assign out_valid = w_main_v;
  assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_v}};

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_main_v && !out_ready && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (SKID=1, SKID=0, SKID=1 with a 4-bit
// counter) share stimulus and are compared against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_ctrl = '0;
  logic [95:0] in_data = '0;

  wire [2:0]       ir;
  wire [2:0]       ov;
  wire [2:0][7:0]  oc;
  wire [2:0][95:0] od;
  wire [2:0][15:0] sc;
  wire [3:0]       sc_c;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_dut_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .stall_cnt(sc[0]));

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_dut_single (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .stall_cnt(sc[1]));

  pipe_stage_reg #(.DATA_W(96), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]), .stall_cnt(sc_c));

  assign sc[2] = {12'b0, sc_c};

  // Reference model: each instance is a FIFO of capacity 2 (skid) or 1 (single).
  int          m_n[3];
  logic [7:0]  m_c[3][2];
  logic [95:0] m_d[3][2];
  logic [95:0] m_last[3];
  int unsigned m_cnt[3];
  bit          m_rdy[3];
  int unsigned cmax[3] = '{65535, 65535, 15};

  function automatic bit is_skid(int k);
    return (k != 1);
  endfunction

  function automatic bit exp_ir(int k);
    if (is_skid(k)) return m_rdy[k];
    return out_ready || (m_n[k] == 0);
  endfunction

  function automatic logic [7:0] exp_oc(int k);
    return (m_n[k] > 0) ? m_c[k][0] : 8'h00;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit ina, outa;
      ina  = in_valid && exp_ir(k);
      outa = (m_n[k] > 0) && out_ready;
      if (reset) begin
        m_n[k] = 0; m_last[k] = '0; m_cnt[k] = 0;
      end else begin
        if (m_n[k] > 0 && !out_ready && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (flush) m_n[k] = 0;
        else begin
          if (outa) begin
            m_c[k][0] = m_c[k][1]; m_d[k][0] = m_d[k][1]; m_n[k]--;
          end
          if (ina) begin
            m_c[k][m_n[k]] = in_ctrl; m_d[k][m_n[k]] = in_data; m_n[k]++;
          end
          if (m_n[k] > 0) m_last[k] = m_d[k][0];
        end
      end
      m_rdy[k] = (m_n[k] < 2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = {3{32'hDEADBEEF}}; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cyc();
      checks++; if (ov[0] !== 1'b0) begin errs++; $display("FAIL reset_ov got %b exp 0", ov[0]); end
      checks++; if (oc[0] !== 8'h00) begin errs++; $display("FAIL reset_oc got %h exp 00", oc[0]); end
      checks++; if (od[0] !== 96'h0) begin errs++; $display("FAIL reset_od got %h exp 0", od[0]); end
      checks++; if (sc[0] !== 16'h0) begin errs++; $display("FAIL reset_sc got %0d exp 0", sc[0]); end
    end
    reset = 1'b0; in_valid = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      checks++; if (ir[k] !== 1'b1) begin errs++; $display("FAIL reset_ir[%0d] got %b exp 1", k, ir[k]); end
    end
  endtask

  task automatic test_stream();
    logic [7:0] c;
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      c = 8'($urandom);
      in_valid = 1'b1; in_ctrl = c; in_data = 96'(i);
      for (int k = 0; k < 2; k++) begin
        checks++; if (ir[k] !== 1'b1) begin errs++; $display("FAIL stream_ir[%0d] i=%0d got %b exp 1", k, i, ir[k]); end
      end
      cyc();
      for (int k = 0; k < 3; k++) begin
        checks++; if (ov[k] !== 1'b1 || od[k] !== 96'(i) || oc[k] !== c) begin
          errs++; $display("FAIL stream_out[%0d] i=%0d got v=%b d=%0h c=%h exp v=1 d=%0h c=%h", k, i, ov[k], od[k], oc[k], i, c);
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      checks++; if (ov[k] !== 1'b0) begin errs++; $display("FAIL stream_end_ov[%0d] got %b exp 0", k, ov[k]); end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h01; in_data = 96'hA;
    cyc();
    checks++; if (ov[0] !== 1'b1 || od[0] !== 96'hA || ir[0] !== 1'b1 || sc[0] !== 16'd0) begin
      errs++; $display("FAIL stall_a got v=%b d=%0h r=%b cnt=%0d exp 1 a 1 0", ov[0], od[0], ir[0], sc[0]);
    end
    in_ctrl = 8'h02; in_data = 96'hB;
    cyc();
    checks++; if (ir[0] !== 1'b0 || sc[0] !== 16'd1 || od[0] !== 96'hA) begin
      errs++; $display("FAIL stall_full got r=%b cnt=%0d d=%0h exp 0 1 a", ir[0], sc[0], od[0]);
    end
    in_ctrl = 8'h04; in_data = 96'hC;
    cyc();
    checks++; if (ir[0] !== 1'b0 || sc[0] !== 16'd2 || oc[0] !== 8'h01) begin
      errs++; $display("FAIL stall_hold got r=%b cnt=%0d c=%h exp 0 2 01", ir[0], sc[0], oc[0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    checks++; if (ov[0] !== 1'b1 || od[0] !== 96'hB || oc[0] !== 8'h02 || ir[0] !== 1'b1 || sc[0] !== 16'd2) begin
      errs++; $display("FAIL stall_drain_b got v=%b d=%0h c=%h r=%b cnt=%0d exp 1 b 02 1 2", ov[0], od[0], oc[0], ir[0], sc[0]);
    end
    cyc();
    checks++; if (ov[0] !== 1'b0 || sc[0] !== 16'd2) begin
      errs++; $display("FAIL stall_empty got v=%b cnt=%0d exp 0 2", ov[0], sc[0]);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11; in_data = 96'h1111;
    cyc();
    in_ctrl = 8'h22; in_data = 96'h2222;
    cyc();
    flush = 1'b1; in_ctrl = 8'h05; in_data = 96'h5555;
    cyc();
    checks++; if (ov[0] !== 1'b0 || oc[0] !== 8'h00 || ir[0] !== 1'b1) begin
      errs++; $display("FAIL flush_kill got v=%b c=%h r=%b exp 0 00 1", ov[0], oc[0], ir[0]);
    end
    checks++; if (sc[0] !== 16'd4 || od[0] !== 96'h1111) begin
      errs++; $display("FAIL flush_hold got cnt=%0d d=%0h exp 4 1111", sc[0], od[0]);
    end
    flush = 1'b0; out_ready = 1'b1; in_ctrl = 8'h03; in_data = 96'h3333;
    cyc();
    checks++; if (ov[0] !== 1'b1 || od[0] !== 96'h3333 || oc[0] !== 8'h03) begin
      errs++; $display("FAIL flush_after got v=%b d=%0h c=%h exp 1 3333 03", ov[0], od[0], oc[0]);
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_bubble();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h0F; in_data = 96'hD0D0;
    cyc();
    for (int k = 0; k < 2; k++) begin
      checks++; if (oc[k] !== 8'h0F) begin errs++; $display("FAIL bubble_load[%0d] got %h exp 0f", k, oc[k]); end
    end
    in_valid = 1'b0; in_ctrl = 8'hFF; in_data = 96'hBAD;
    for (int c = 0; c < 3; c++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++; if (ov[k] !== 1'b0 || oc[k] !== 8'h00 || od[k] !== 96'hD0D0) begin
          errs++; $display("FAIL bubble_nop[%0d] c=%0d got v=%b c=%h d=%0h exp 0 00 d0d0", k, c, ov[k], oc[k], od[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    cyc();
    reset = 1'b0; in_valid = 1'b1; in_ctrl = 8'h08; in_data = 96'h5A; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      checks++; if (sc[2] !== 16'((i > 15) ? 15 : i) || sc[0] !== 16'(i)) begin
        errs++; $display("FAIL sat_cnt i=%0d got c4=%0d c16=%0d exp %0d %0d", i, sc[2], sc[0], (i > 15) ? 15 : i, i);
      end
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++; if (sc[2] !== 16'd15 || sc[0] !== 16'd21) begin
      errs++; $display("FAIL sat_later got c4=%0d c16=%0d exp 15 21", sc[2], sc[0]);
    end
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (ov[k] !== (m_n[k] > 0)) begin errs++; $display("FAIL rand_ov[%0d] n=%0d got %b exp %b", k, n, ov[k], m_n[k] > 0); end
        checks++; if (oc[k] !== exp_oc(k)) begin errs++; $display("FAIL rand_oc[%0d] n=%0d got %h exp %h", k, n, oc[k], exp_oc(k)); end
        checks++; if (od[k] !== m_last[k]) begin errs++; $display("FAIL rand_od[%0d] n=%0d got %h exp %h", k, n, od[k], m_last[k]); end
        checks++; if (sc[k] !== 16'(m_cnt[k])) begin errs++; $display("FAIL rand_sc[%0d] n=%0d got %0d exp %0d", k, n, sc[k], m_cnt[k]); end
        checks++; if (ir[k] !== exp_ir(k)) begin errs++; $display("FAIL rand_ir[%0d] n=%0d got %b exp %b", k, n, ir[k], exp_ir(k)); end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      cyc();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
